uart_recv: RTL

Serial receiver for the board UART link: the downstream counterpart of the `uart` transmitter. It consumes the 8N1 serial line that `uart` drives on `s_out`, oversamples it at 16× the baud rate using a fractional phase accumulator, and delivers each received byte as a one-cycle `valid` pulse with `data_out`. Framing errors are flagged and the offending byte is discarded. The block sits between the pad and the byte-level consumer, which is a command parser or the loopback path.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_recv_if.sv | 33 +++
 rtl/uart_baud_tick.sv | 42 ++++
 rtl/uart_recv.sv | 137 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared types and constants for the UART receive path
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned MID         = 7;
  localparam int unsigned ACC_INC_DEF = 288;
  localparam int unsigned ACC_MOD_DEF = 15625;

endpackage

`default_nettype wire

// File: rtl/uart_recv_if.sv
// ============================================================================
// uart_recv_if : serial input and byte-level outputs of the UART receiver
// Rev 1.0
// ============================================================================
`default_nettype none

interface uart_recv_if;

  logic       s_in;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  s_in,
    output data_out,
    output valid,
    output frame_err,
    output busy
  );

  modport slave (
    output s_in,
    input  data_out,
    input  valid,
    input  frame_err,
    input  busy
  );

endinterface

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// uart_baud_tick : fractional phase accumulator producing the 16x baud tick
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned ACC_INC = ACC_INC_DEF,
  parameter int unsigned ACC_MOD = ACC_MOD_DEF,
  parameter int unsigned ACC_W   = 16
) (
  input  wire  clk,
  input  wire  rst_n,
  output logic tick_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   sum_w;

  // One extra bit so the wrap comparison cannot overflow.
  assign sum_w = {1'b0, acc_q} + (ACC_W+1)'(ACC_INC);

  always_comb begin
    tick_o = 1'b0;
    acc_d  = sum_w[ACC_W-1:0];
    if (sum_w >= (ACC_W+1)'(ACC_MOD)) begin
      tick_o = 1'b1;
      acc_d  = ACC_W'(sum_w - (ACC_W+1)'(ACC_MOD));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

`default_nettype wire

// File: rtl/uart_recv.sv
// ============================================================================
// uart_recv : 8N1 serial receiver, 16x oversampled with mid-bit sampling
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_recv
  import uart_pkg::*;
#(
  parameter int unsigned ACC_INC = ACC_INC_DEF,
  parameter int unsigned ACC_MOD = ACC_MOD_DEF,
  parameter int unsigned ACC_W   = 16
) (
  input  wire         clk,
  input  wire         rst_n,
  uart_recv_if.master bus
);

  localparam logic [3:0] C_MID  = 4'(MID);
  localparam logic [3:0] C_LAST = 4'(OVERSAMPLE - 1);

  logic       tick_w;
  logic [1:0] sync_q;
  logic       rx_w;

  state_e     state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       seen_q, seen_d;

  uart_baud_tick #(
    .ACC_INC (ACC_INC),
    .ACC_MOD (ACC_MOD),
    .ACC_W   (ACC_W)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick_w)
  );

  assign rx_w = sync_q[1];

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    seen_d  = seen_q;
    if (tick_w) begin
      case (state_q)
        IDLE: begin
          // A start is only accepted once the line has idled high since the last frame.
          if (rx_w) begin
            seen_d = 1'b1;
          end else if (seen_q) begin
            state_d = START;
            tcnt_d  = 4'd0;
          end
        end
        START: begin
          if (tcnt_q == C_MID) begin
            tcnt_d  = 4'd0;
            bcnt_d  = 3'd0;
            state_d = rx_w ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
        DATA: begin
          if (tcnt_q == C_LAST) begin
            tcnt_d = 4'd0;
            sh_d   = {rx_w, sh_q[7:1]};
            if (bcnt_q == 3'd7) state_d = STOP;
            else                bcnt_d  = bcnt_q + 3'd1;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
        STOP: begin
          if (tcnt_q == C_LAST) begin
            tcnt_d  = 4'd0;
            seen_d  = 1'b0;
            state_d = IDLE;
            if (rx_w) begin
              data_d  = sh_q;
              valid_d = 1'b1;
            end else begin
              ferr_d  = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      tcnt_q  <= 4'd0;
      bcnt_q  <= 3'd0;
      sh_q    <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      seen_q  <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], bus.s_in};
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      seen_q  <= seen_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

`default_nettype wire
